// File: rtl/uart_rx_command_controller_pkg.sv
// Shared constants for the UART command controller: opcodes, FSM state
// encodings, fixed RF addresses for the ALU operands and an opcode decoder.
package uart_rx_command_controller_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ALU_WIDTH  = 16;

  // Command opcodes, received as the first byte of a frame
  localparam logic [7:0] OP_WR       = 8'hAA;
  localparam logic [7:0] OP_RD       = 8'hBB;
  localparam logic [7:0] OP_ALU      = 8'hCC;
  localparam logic [7:0] OP_ALU_NOOP = 8'hDD;

  // RF locations the ALU reads its operands from
  localparam logic [DEF_ADDR_WIDTH-1:0] OPA_ADDR = 4'd0;
  localparam logic [DEF_ADDR_WIDTH-1:0] OPB_ADDR = 4'd1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_OPA  = 4'd5,
    ST_ALU_OPB  = 4'd6,
    ST_ALU_FUNC = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LSB   = 4'd9,
    ST_TX_MSB   = 4'd10
  } state_t;

  // First state of a frame for a given opcode; ST_IDLE marks an unknown opcode
  function automatic state_t opcode_state(input logic [7:0] op);
    state_t s;
    s = ST_IDLE;
    case (op)
      OP_WR:       s = ST_WR_ADDR;
      OP_RD:       s = ST_RD_ADDR;
      OP_ALU:      s = ST_ALU_OPA;
      OP_ALU_NOOP: s = ST_ALU_FUNC;
      default:     s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_command_controller_cmd_response_tx.sv
// Response transmitter: loads one or two bytes and presents them in order on
// a registered valid/ready interface.
//
// Handshake: a byte transfers on every cycle where tx_valid and tx_ready are
// both high. tx_valid and tx_data hold steady until that transfer; tx_ready
// is ignored while tx_valid is low. After the first byte of a two-byte load
// transfers, the second byte is presented on the following cycle.
module cmd_response_tx
  import uart_rx_command_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  two_bytes,
  input  logic [DATA_WIDTH-1:0] lsb,
  input  logic [DATA_WIDTH-1:0] msb,
  input  logic                  abort,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  accept,
  output logic                  done
);

  logic                  pending_q;
  logic [DATA_WIDTH-1:0] msb_q;

  assign accept = tx_valid & tx_ready;
  assign done   = accept & ~pending_q;

  // Byte sequencing: abort drops everything, load starts a response, accept advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      pending_q <= 1'b0;
      msb_q     <= '0;
    end else if (abort) begin
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      pending_q <= 1'b0;
    end else if (load) begin
      tx_data   <= lsb;
      tx_valid  <= 1'b1;
      pending_q <= two_bytes;
      msb_q     <= msb;
    end else if (accept) begin
      if (pending_q) begin
        tx_data   <= msb_q;
        pending_q <= 1'b0;
      end else begin
        tx_data  <= '0;
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_command_controller.sv
// UART command controller: parses received byte frames into RF writes/reads
// and ALU operations, and returns read data / ALU results as response bytes.
module uart_rx_command_controller
  import uart_rx_command_controller_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ALU_WIDTH  = DEF_ALU_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_parity_error,
  input  logic                  rx_frame_error,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic                  alu_en,
  output logic [3:0]            alu_func,
  output logic                  alu_clk_en,
  input  logic [ALU_WIDTH-1:0]  alu_result,
  input  logic                  alu_result_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  cmd_error,
  output logic [3:0]            debug_state
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ALU_WIDTH-1:0]  result_q, result_d;

  logic                  wr_en_d, rd_en_d, alu_en_d, err_d, clk_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [3:0]            func_d;

  logic                  rx_err;
  logic                  tx_load, tx_two, tx_abort;
  logic                  tx_accept, tx_done;

  assign rx_err      = rx_parity_error | rx_frame_error;
  assign busy        = (state_q != ST_IDLE);
  assign debug_state = state_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, strobe requests and datapath captures; rx errors override everything
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    result_d  = result_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    err_d     = 1'b0;
    clk_en_d  = alu_clk_en;
    rf_addr_d = rf_addr;
    wr_data_d = rf_wr_data;
    func_d    = alu_func;
    tx_load   = 1'b0;
    tx_two    = 1'b0;
    tx_abort  = 1'b0;

    if (rx_err) begin
      state_d  = ST_IDLE;
      err_d    = 1'b1;
      clk_en_d = 1'b0;
      tx_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data_valid) begin
            state_d = opcode_state(rx_data);
            if (state_d == ST_IDLE) err_d = 1'b1;
          end
        end
        ST_WR_ADDR: begin
          if (rx_data_valid) begin
            addr_d  = rx_data[ADDR_WIDTH-1:0];
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (rx_data_valid) begin
            wr_en_d   = 1'b1;
            rf_addr_d = addr_q;
            wr_data_d = rx_data;
            state_d   = ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (rx_data_valid) begin
            rd_en_d   = 1'b1;
            addr_d    = rx_data[ADDR_WIDTH-1:0];
            rf_addr_d = rx_data[ADDR_WIDTH-1:0];
            state_d   = ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (rx_data_valid) err_d = 1'b1;
          if (rf_rd_valid) begin
            result_d = {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, rf_rd_data};
            tx_load  = 1'b1;
            state_d  = ST_TX_LSB;
          end
        end
        ST_ALU_OPA: begin
          if (rx_data_valid) begin
            wr_en_d   = 1'b1;
            rf_addr_d = ADDR_WIDTH'(OPA_ADDR);
            wr_data_d = rx_data;
            state_d   = ST_ALU_OPB;
          end
        end
        ST_ALU_OPB: begin
          if (rx_data_valid) begin
            wr_en_d   = 1'b1;
            rf_addr_d = ADDR_WIDTH'(OPB_ADDR);
            wr_data_d = rx_data;
            state_d   = ST_ALU_FUNC;
          end
        end
        ST_ALU_FUNC: begin
          if (rx_data_valid) begin
            alu_en_d = 1'b1;
            clk_en_d = 1'b1;
            func_d   = rx_data[3:0];
            state_d  = ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (rx_data_valid) err_d = 1'b1;
          if (alu_result_valid) begin
            result_d = alu_result;
            clk_en_d = 1'b0;
            tx_load  = 1'b1;
            tx_two   = 1'b1;
            state_d  = ST_TX_LSB;
          end
        end
        ST_TX_LSB: begin
          if (rx_data_valid) err_d = 1'b1;
          if (tx_accept) state_d = tx_done ? ST_IDLE : ST_TX_MSB;
        end
        ST_TX_MSB: begin
          if (rx_data_valid) err_d = 1'b1;
          if (tx_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered strobes, RF/ALU outputs and captured address/result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_en     <= 1'b0;
      alu_func   <= 4'd0;
      alu_clk_en <= 1'b0;
      cmd_error  <= 1'b0;
      addr_q     <= '0;
      result_q   <= '0;
    end else begin
      rf_wr_en   <= wr_en_d;
      rf_rd_en   <= rd_en_d;
      rf_addr    <= rf_addr_d;
      rf_wr_data <= wr_data_d;
      alu_en     <= alu_en_d;
      alu_func   <= func_d;
      alu_clk_en <= clk_en_d;
      cmd_error  <= err_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
    end
  end

  cmd_response_tx #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .two_bytes(tx_two),
    .lsb      (result_d[DATA_WIDTH-1:0]),
    .msb      (result_d[ALU_WIDTH-1:DATA_WIDTH]),
    .abort    (tx_abort),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .accept   (tx_accept),
    .done     (tx_done)
  );

endmodule
